// File: rtl/dl_bus_arbiter_if.sv
// Bundle of the DL bus request/grant/data signals shared between the
// arbiter (slave side) and the four requesters plus bus observers (master side).
interface dl_bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] din;
    logic               BUS_DISABLE;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic               precharge;
    logic [W-1:0]       DL;
    logic [W-1:0]       DLq;
    logic               busy;

    // Requester / environment side
    modport master (
        output req, din, BUS_DISABLE,
        input  gnt, ack, precharge, DL, DLq, busy
    );

    // Arbiter side
    modport slave (
        input  req, din, BUS_DISABLE,
        output gnt, ack, precharge, DL, DLq, busy
    );
endinterface

// File: rtl/dl_bus_arbiter.sv
// Round-robin arbiter and precharge/drive/sample sequencer for the 8-bit DL bus.
// Every output is decoded from registered state, so req never reaches gnt/ack
// combinationally. DLq acts as the bus keeper holding the last completed value.
module dl_bus_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic              CLK,
    input  logic              SYNC_RES,
    dl_bus_arbiter_if.slave   bus
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [W-1:0] BUS_IDLE = {W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    state_t          state_reg,  state_next;
    logic [PW-1:0]   winner_reg, winner_next;
    logic [PW-1:0]   ptr_reg,    ptr_next;
    logic [W-1:0]    data_reg,   data_next;
    logic [W-1:0]    dlq_reg,    dlq_next;

    logic [W-1:0]    din_slot [N_REQ];
    logic [N_REQ-1:0] winner_onehot;
    logic [PW-1:0]   scan_base;
    logic [PW-1:0]   rr_winner;
    logic            eligible;
    logic            winner_req;

    // Split the packed data bus into per-requester slots and decode the
    // registered winner into a one-hot vector.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign din_slot[gi]      = bus.din[gi*W +: W];
            assign winner_onehot[gi] = (winner_reg == PW'(gi));
        end
    endgenerate

    assign eligible   = (|bus.req) & ~bus.BUS_DISABLE;
    assign winner_req = bus.req[winner_reg];

    // Round-robin scan. Out of SAMPLE the pointer update (winner + 1) has not
    // landed in ptr_reg yet, so the back-to-back scan starts from it directly.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        scan_base = (state_reg == ST_SAMPLE) ? PW'(winner_reg + 1'b1) : ptr_reg;
        rr_winner = scan_base;
        // Walk from the farthest slot back to the base so the nearest
        // asserted request is the one left in rr_winner.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = scan_base + PW'(k);
            if (bus.req[idx]) begin
                rr_winner = idx;
            end
        end
    end

    // State register together with latched winner, pointer, data and keeper.
    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            state_reg  <= ST_IDLE;
            winner_reg <= '0;
            ptr_reg    <= '0;
            data_reg   <= BUS_IDLE;
            dlq_reg    <= BUS_IDLE;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            ptr_reg    <= ptr_next;
            data_reg   <= data_next;
            dlq_reg    <= dlq_next;
        end
    end

    // Next-state logic: arbitration in IDLE/SAMPLE, abort on a dropped winner
    // request in PRE/DRIVE, data capture entering DRIVE, keeper update leaving SAMPLE.
    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        ptr_next    = ptr_reg;
        data_next   = data_reg;
        dlq_next    = dlq_reg;
        case (state_reg)
            ST_IDLE: begin
                if (eligible) begin
                    state_next  = ST_PRE;
                    winner_next = rr_winner;
                end
            end
            ST_PRE: begin
                if (winner_req) begin
                    state_next = ST_DRIVE;
                    data_next  = din_slot[winner_reg];
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_next = winner_req ? ST_SAMPLE : ST_IDLE;
            end
            ST_SAMPLE: begin
                ptr_next = PW'(winner_reg + 1'b1);
                dlq_next = data_reg;
                if (eligible) begin
                    state_next  = ST_PRE;
                    winner_next = rr_winner;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode, purely from registered state, winner and data.
    always_comb begin
        bus.gnt       = '0;
        bus.ack       = '0;
        bus.precharge = 1'b1;
        bus.DL        = BUS_IDLE;
        bus.DLq       = dlq_reg;
        bus.busy      = (state_reg != ST_IDLE);
        case (state_reg)
            ST_PRE: begin
                bus.gnt = winner_onehot;
            end
            ST_DRIVE: begin
                bus.gnt       = winner_onehot;
                bus.precharge = 1'b0;
                bus.DL        = data_reg;
            end
            ST_SAMPLE: begin
                bus.gnt       = winner_onehot;
                bus.ack       = winner_onehot;
                bus.precharge = 1'b0;
                bus.DL        = data_reg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dl_bus_arbiter.sv
// Directed-vector bench for dl_bus_arbiter with hand-computed cycle-by-cycle
// expectations for each scenario.
module tb_dl_bus_arbiter;
    logic CLK = 1'b0;
    logic SYNC_RES;

    always #5 CLK = ~CLK;

    dl_bus_arbiter_if #(.N_REQ(4), .W(8)) bus_if ();

    dl_bus_arbiter #(.N_REQ(4), .W(8)) dut (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .bus      (bus_if)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    // Checks all observable outputs for one cycle and prints one line for it.
    task automatic exp_cyc(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic p, input logic [7:0] dl, input logic [7:0] dlq,
                           input logic b);
        chk({tag, ".gnt"},  32'(bus_if.gnt),       32'(g));
        chk({tag, ".ack"},  32'(bus_if.ack),       32'(a));
        chk({tag, ".pre"},  32'(bus_if.precharge), 32'(p));
        chk({tag, ".DL"},   32'(bus_if.DL),        32'(dl));
        chk({tag, ".DLq"},  32'(bus_if.DLq),       32'(dlq));
        chk({tag, ".busy"}, 32'(bus_if.busy),      32'(b));
        $display("%-12s gnt=%b ack=%b pre=%b DL=%h DLq=%h busy=%b", tag,
                 bus_if.gnt, bus_if.ack, bus_if.precharge, bus_if.DL, bus_if.DLq, bus_if.busy);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        SYNC_RES = 1'b1;
        tick();
        SYNC_RES = 1'b0;
    endtask

    initial begin
        logic [7:0] dlq_prev;
        logic [3:0] w_oh;
        logic [7:0] w_dat;

        SYNC_RES           = 1'b1;
        bus_if.req         = 4'b0000;
        bus_if.din         = 32'h0;
        bus_if.BUS_DISABLE = 1'b0;

        // ---- reset values ----
        tick();
        exp_cyc("reset", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b0);
        SYNC_RES = 1'b0;
        tick();
        exp_cyc("idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b0);

        // ---- single transfer, requester 1, data 5A ----
        bus_if.din = 32'h0000_5A00;
        bus_if.req = 4'b0010;
        tick(); exp_cyc("t1.pre",  4'b0010, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick(); exp_cyc("t1.drv",  4'b0010, 4'b0000, 1'b0, 8'h5A, 8'hFF, 1'b1);
        tick(); exp_cyc("t1.smp",  4'b0010, 4'b0010, 1'b0, 8'h5A, 8'hFF, 1'b1);
        bus_if.req = 4'b0000;
        tick(); exp_cyc("t1.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b0);

        // ---- abort in DRIVE (ptr is 2 now), then ptr must still be 2 ----
        bus_if.din = 32'h0077_5A00;
        bus_if.req = 4'b0100;
        tick(); exp_cyc("ab.pre",  4'b0100, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b1);
        tick(); exp_cyc("ab.drv",  4'b0100, 4'b0000, 1'b0, 8'h77, 8'h5A, 1'b1);
        bus_if.req = 4'b0000;
        tick(); exp_cyc("ab.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b0);
        bus_if.req = 4'b0101;
        tick(); exp_cyc("ab.ptr",  4'b0100, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b1);
        // abort in PRE as well
        bus_if.req = 4'b0000;
        tick(); exp_cyc("abp.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b0);

        // ---- all four requesting: order 0,1,2,3,0 back-to-back ----
        do_reset();
        bus_if.din = 32'h3322_1100;
        bus_if.req = 4'b1111;
        dlq_prev = 8'hFF;
        for (int t = 0; t < 5; t++) begin
            w_oh  = 4'b0001 << (t % 4);
            w_dat = 8'h11 * 8'(t % 4);
            tick(); exp_cyc($sformatf("rr%0d.pre", t), w_oh, 4'b0000, 1'b1, 8'hFF, dlq_prev, 1'b1);
            tick(); exp_cyc($sformatf("rr%0d.drv", t), w_oh, 4'b0000, 1'b0, w_dat, dlq_prev, 1'b1);
            tick(); exp_cyc($sformatf("rr%0d.smp", t), w_oh, w_oh,    1'b0, w_dat, dlq_prev, 1'b1);
            dlq_prev = w_dat;
        end
        bus_if.req = 4'b0000;
        tick(); exp_cyc("rr.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h00, 1'b0);

        // ---- BUS_DISABLE holds off, then mid-transfer disable completes ----
        do_reset();
        bus_if.din         = 32'h0000_00A5;
        bus_if.req         = 4'b0001;
        bus_if.BUS_DISABLE = 1'b1;
        repeat (3) tick();
        exp_cyc("bd.hold", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b0);
        bus_if.BUS_DISABLE = 1'b0;
        tick(); exp_cyc("bd.pre",  4'b0001, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick(); exp_cyc("bd.drv",  4'b0001, 4'b0000, 1'b0, 8'hA5, 8'hFF, 1'b1);
        bus_if.BUS_DISABLE = 1'b1;
        tick(); exp_cyc("bd.smp",  4'b0001, 4'b0001, 1'b0, 8'hA5, 8'hFF, 1'b1);
        tick(); exp_cyc("bd.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hA5, 1'b0);
        tick(); exp_cyc("bd.idle2", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hA5, 1'b0);
        bus_if.BUS_DISABLE = 1'b0;
        bus_if.req         = 4'b0000;

        // ---- reset during SAMPLE of a C3 transfer ----
        do_reset();
        bus_if.din = 32'h0000_5AC3;
        bus_if.req = 4'b0010;
        tick(); tick(); tick();
        exp_cyc("rs.smp1", 4'b0010, 4'b0010, 1'b0, 8'h5A, 8'hFF, 1'b1);
        bus_if.req = 4'b0001;
        tick(); exp_cyc("rs.pre",  4'b0001, 4'b0000, 1'b1, 8'hFF, 8'h5A, 1'b1);
        tick(); exp_cyc("rs.drv",  4'b0001, 4'b0000, 1'b0, 8'hC3, 8'h5A, 1'b1);
        tick(); exp_cyc("rs.smp",  4'b0001, 4'b0001, 1'b0, 8'hC3, 8'h5A, 1'b1);
        SYNC_RES = 1'b1;
        tick(); exp_cyc("rs.rst",  4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b0);
        SYNC_RES   = 1'b0;
        bus_if.req = 4'b1001;
        tick(); exp_cyc("rs.pre2", 4'b0001, 4'b0000, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick(); exp_cyc("rs.drv2", 4'b0001, 4'b0000, 1'b0, 8'hC3, 8'hFF, 1'b1);
        tick(); exp_cyc("rs.smp2", 4'b0001, 4'b0001, 1'b0, 8'hC3, 8'hFF, 1'b1);
        bus_if.req = 4'b0000;
        tick(); exp_cyc("rs.idle", 4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hC3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
